lcd_init_sequencer: RTL and testbench

- Walks the 16-bit LCD init-data ROM (7-bit address, combinational read) from address 0.
- Decodes each word as command, pixel/parameter data, delay or end marker.
- Pushes command and data bytes to the LCD bus writer over a valid/ready handshake.
- Sits between the init ROM and the LCD bus driver. Asserts done when the panel is configured so the frame printer may take the bus.

---
 rtl/lcd_init_pkg.sv | 29 ++
 rtl/lcd_init_sequencer_ms_timer.sv | 46 ++++
 rtl/lcd_init_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_lcd_init_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_init_pkg.sv
// Shared encodings for the LCD init-ROM sequencer: word tags, field positions and FSM states.
package lcd_init_pkg;

    localparam int TAG_HI  = 15;
    localparam int TAG_LO  = 14;
    localparam int MS_HI   = 13;
    localparam int BYTE_HI = 7;
    localparam int MS_W    = MS_HI + 1;

    localparam logic [1:0] TAG_CMD   = 2'b00;
    localparam logic [1:0] TAG_DATA  = 2'b01;
    localparam logic [1:0] TAG_DELAY = 2'b10;
    localparam logic [1:0] TAG_END   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HWRST,
        ST_HWWAIT,
        ST_FETCH,
        ST_ISSUE,
        ST_DELAY,
        ST_DONE
    } state_e;

    function automatic logic [1:0] word_tag(input logic [15:0] word);
        return word[TAG_HI:TAG_LO];
    endfunction

endpackage

// File: rtl/lcd_init_sequencer_ms_timer.sv
// Millisecond timer: prescaler of CLKS_PER_MS cycles feeding a ms down-counter.
// expired_o is high during the last cycle of the programmed interval.
module lcd_ms_timer
    import lcd_init_pkg::*;
#(
    parameter int CLKS_PER_MS = 50000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic [MS_W-1:0] ms_i,
    output logic            expired_o
);

    localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [PW-1:0] PRESC_TOP = PW'(CLKS_PER_MS - 1);

    logic [PW-1:0]   presc_q;
    logic [MS_W-1:0] ms_q;
    logic            active_q;

    // Combinational so the owner can leave its wait state on the final tick itself.
    assign expired_o = active_q && (presc_q == '0) && (ms_q == MS_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q  <= '0;
            ms_q     <= '0;
            active_q <= 1'b0;
        end else if (load_i) begin
            presc_q  <= PRESC_TOP;
            ms_q     <= ms_i;
            active_q <= (ms_i != '0);
        end else if (active_q) begin
            if (presc_q == '0) begin
                presc_q <= PRESC_TOP;
                ms_q    <= ms_q - MS_W'(1);
                if (ms_q == MS_W'(1))
                    active_q <= 1'b0;
            end else begin
                presc_q <= presc_q - PW'(1);
            end
        end
    end

endmodule

// File: rtl/lcd_init_sequencer.sv
// Walks the LCD init ROM, issuing command/data bytes, delays and the end marker.
// Optional panel hardware-reset phase is built when LCD_HW_RESET_EN is defined.
module lcd_init_sequencer
    import lcd_init_pkg::*;
#(
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 16,
    parameter int CLKS_PER_MS = 50000,
    parameter int HWRST_MS    = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic                  wr_dc,
    output logic [7:0]            wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  lcd_rst_n
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] rom_addr_q;
    logic                  wr_valid_q;
    logic                  wr_dc_q;
    logic [7:0]            wr_data_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;

    logic [1:0]      tag;
    logic [MS_W-1:0] word_ms;
    logic            tmr_load;
    logic [MS_W-1:0] tmr_ms;
    logic            tmr_expired;
    logic            at_last;

    assign tag     = word_tag(rom_data[15:0]);
    assign word_ms = rom_data[MS_HI:0];
    assign at_last = (rom_addr_q == ADDR_LAST);

    always_comb begin
        tmr_load = 1'b0;
        tmr_ms   = word_ms;
        case (state_q)
            ST_FETCH: tmr_load = (tag == TAG_DELAY) && (word_ms != '0);
`ifdef LCD_HW_RESET_EN
            ST_IDLE, ST_DONE: begin
                tmr_load = start;
                tmr_ms   = MS_W'(HWRST_MS);
            end
            ST_HWRST: begin
                tmr_load = tmr_expired;
                tmr_ms   = MS_W'(HWRST_MS);
            end
`endif
            default: ;
        endcase
    end

    lcd_ms_timer #(.CLKS_PER_MS(CLKS_PER_MS)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (tmr_load),
        .ms_i      (tmr_ms),
        .expired_o (tmr_expired)
    );

`ifdef LCD_HW_RESET_EN
    logic lcd_rst_q;
    assign lcd_rst_n = lcd_rst_q;
`else
    assign lcd_rst_n = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rom_addr_q <= '0;
            wr_valid_q <= 1'b0;
            wr_dc_q    <= 1'b0;
            wr_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef LCD_HW_RESET_EN
            lcd_rst_q  <= 1'b1;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        rom_addr_q <= '0;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        busy_q     <= 1'b1;
`ifdef LCD_HW_RESET_EN
                        lcd_rst_q  <= 1'b0;
                        state_q    <= ST_HWRST;
`else
                        state_q    <= ST_FETCH;
`endif
                    end
                end
`ifdef LCD_HW_RESET_EN
                ST_HWRST: begin
                    if (tmr_expired) begin
                        lcd_rst_q <= 1'b1;
                        state_q   <= ST_HWWAIT;
                    end
                end
                ST_HWWAIT: begin
                    if (tmr_expired)
                        state_q <= ST_FETCH;
                end
`endif
                ST_FETCH: begin
                    case (tag)
                        TAG_CMD, TAG_DATA: begin
                            wr_data_q  <= rom_data[BYTE_HI:0];
                            wr_dc_q    <= (tag == TAG_DATA);
                            wr_valid_q <= 1'b1;
                            state_q    <= ST_ISSUE;
                        end
                        TAG_DELAY: begin
                            if (word_ms != '0) begin
                                state_q <= ST_DELAY;
                            end else if (at_last) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                                err_q   <= 1'b1;
                                busy_q  <= 1'b0;
                            end else begin
                                rom_addr_q <= rom_addr_q + 1'b1;
                            end
                        end
                        default: begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    endcase
                end
                ST_ISSUE: begin
                    if (wr_ready) begin
                        wr_valid_q <= 1'b0;
                        if (at_last) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            rom_addr_q <= rom_addr_q + 1'b1;
                            state_q    <= ST_FETCH;
                        end
                    end
                end
                ST_DELAY: begin
                    if (tmr_expired) begin
                        if (at_last) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            rom_addr_q <= rom_addr_q + 1'b1;
                            state_q    <= ST_FETCH;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rom_addr = rom_addr_q;
    assign wr_valid = wr_valid_q;
    assign wr_dc    = wr_dc_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// Directed bench for lcd_init_sequencer with CLKS_PER_MS=4 and HWRST_MS=2.
module tb_lcd_init_sequencer;

    localparam int CLKS = 4;
    localparam int HWMS = 2;
`ifdef LCD_HW_RESET_EN
    localparam int PRE = 2 * HWMS * CLKS;
`else
    localparam int PRE = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  rom_addr;
    logic [15:0] rom_data;
    logic        wr_valid;
    logic        wr_ready = 1'b1;
    logic        wr_dc;
    logic [7:0]  wr_data;
    logic        busy;
    logic        done;
    logic        err;
    logic        lcd_rst_n;

    logic [15:0] rom [0:127];
    logic [8:0]  xq [$];
    int          checks_total = 0;
    int          checks_passed = 0;

    assign rom_data = rom[rom_addr];

    lcd_init_sequencer #(
        .ADDR_WIDTH (7),
        .DATA_WIDTH (16),
        .CLKS_PER_MS(CLKS),
        .HWRST_MS   (HWMS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_dc     (wr_dc),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .lcd_rst_n (lcd_rst_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && wr_valid && wr_ready) begin
            xq.push_back({wr_dc, wr_data});
            $display("xfer addr=%0d dc=%0d data=0x%02h", rom_addr, wr_dc, wr_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    endtask

    task automatic skip(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_rom();
        foreach (rom[i]) rom[i] = 16'h0000;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk(tag, {18'd0, rom_addr, wr_valid, wr_dc, wr_data, busy, done, err, lcd_rst_n},
            {18'd0, 7'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1});
    endtask

    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        clear_rom();
        skip(3);
        check_reset_outputs("reset_values");
        rst_n = 1'b1;
        skip(2);
        check_reset_outputs("idle_after_release");

        // Basic CMD, DATA, END sequence
        rom[0] = 16'h0011; rom[1] = 16'h4022; rom[2] = 16'hC000;
        xq.delete();
        pulse_start();
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        skip(PRE + 4);
        chk("done_not_yet", {31'd0, done}, 32'd0);
        skip(1);
        chk("done_5th_cycle", {29'd0, done, busy, err}, {29'd0, 1'b1, 1'b0, 1'b0});
        chk("addr_stops_2", {25'd0, rom_addr}, 32'd2);
        chk("basic_xfer_count", xq.size(), 32'd2);
        if (xq.size() == 2) begin
            chk("basic_xfer0", {23'd0, xq[0]}, {23'd0, 9'h011});
            chk("basic_xfer1", {23'd0, xq[1]}, {23'd0, 9'h122});
        end
        skip(3);
        chk("done_held", {30'd0, done, busy}, {30'd0, 1'b1, 1'b0});

        // Backpressure on the first byte
        clear_rom();
        rom[0] = 16'h00A5; rom[1] = 16'h405A; rom[2] = 16'hC000;
        xq.delete();
        wr_ready = 1'b0;
        pulse_start();
        skip(PRE + 1);
        for (int i = 0; i < 7; i++) begin
            chk("bp_hold", {22'd0, wr_valid, wr_dc, wr_data}, {22'd0, 1'b1, 1'b0, 8'hA5});
            @(negedge clk);
        end
        chk("bp_no_xfer_yet", xq.size(), 32'd0);
        wr_ready = 1'b1;
        wait_done("bp_done", 50);
        chk("bp_xfer_count", xq.size(), 32'd2);
        if (xq.size() == 2) begin
            chk("bp_xfer0", {23'd0, xq[0]}, {23'd0, 9'h0A5});
            chk("bp_xfer1", {23'd0, xq[1]}, {23'd0, 9'h15A});
        end

        // 3 ms delay = 12 prescaler cycles
        clear_rom();
        rom[0] = 16'h8003; rom[1] = 16'hC000;
        xq.delete();
        pulse_start();
        skip(PRE + 12);
        chk("delay_still_addr0", {24'd0, rom_addr, busy}, {24'd0, 7'd0, 1'b1});
        skip(1);
        chk("delay_fetch_addr1", {25'd0, rom_addr}, 32'd1);
        chk("delay_not_done", {31'd0, done}, 32'd0);
        skip(1);
        chk("delay_done", {31'd0, done}, 32'd1);
        chk("delay_no_xfer", xq.size(), 32'd0);

        // Zero-length delay costs one cycle
        clear_rom();
        rom[0] = 16'h8000; rom[1] = 16'h0033; rom[2] = 16'hC000;
        xq.delete();
        pulse_start();
        skip(PRE + 1);
        chk("delay0_addr1", {25'd0, rom_addr}, 32'd1);
        skip(1);
        chk("delay0_issue", {22'd0, wr_valid, wr_dc, wr_data}, {22'd0, 1'b1, 1'b0, 8'h33});
        wait_done("delay0_done", 50);

        // No END: address space exhausted
        clear_rom();
        xq.delete();
        pulse_start();
        wait_done("noend_done", 1000);
        chk("noend_xfers", xq.size(), 32'd128);
        chk("noend_err", {30'd0, err, busy}, {30'd0, 1'b1, 1'b0});
        chk("noend_addr", {25'd0, rom_addr}, 32'd127);
        skip(4);
        chk("noend_no_wrap", {25'd0, rom_addr}, 32'd127);
        rom[0] = 16'hC000;
        pulse_start();
        chk("restart_clears", {29'd0, err, done, busy}, {29'd0, 1'b0, 1'b0, 1'b1});
        wait_done("restart_done", 50);
        chk("restart_err", {31'd0, err}, 32'd0);

        // Asynchronous reset while in ISSUE
        clear_rom();
        rom[0] = 16'h0011; rom[1] = 16'h4022; rom[2] = 16'hC000;
        xq.delete();
        wr_ready = 1'b0;
        pulse_start();
        skip(PRE + 1);
        chk("issue_pending", {31'd0, wr_valid}, 32'd1);
        async_reset("rst_in_issue");
        wr_ready = 1'b1;
        xq.delete();
        pulse_start();
        wait_done("replay1_done", 60);
        chk("replay1_xfers", xq.size(), 32'd2);
        if (xq.size() == 2) chk("replay1_first", {23'd0, xq[0]}, {23'd0, 9'h011});

        // Asynchronous reset while in DELAY
        clear_rom();
        rom[0] = 16'h0055; rom[1] = 16'h8005; rom[2] = 16'hC000;
        xq.delete();
        pulse_start();
        skip(PRE + 5);
        chk("in_delay", {24'd0, rom_addr, busy}, {24'd0, 7'd1, 1'b1});
        async_reset("rst_in_delay");
        xq.delete();
        pulse_start();
        wait_done("replay2_done", 80);
        chk("replay2_xfers", xq.size(), 32'd1);
        if (xq.size() == 1) chk("replay2_first", {23'd0, xq[0]}, {23'd0, 9'h055});

`ifdef LCD_HW_RESET_EN
        clear_rom();
        rom[0] = 16'h0011; rom[1] = 16'hC000;
        pulse_start();
        chk("hw_rst_low_first", {31'd0, lcd_rst_n}, 32'd0);
        skip(7);
        chk("hw_rst_low_last", {30'd0, lcd_rst_n, busy}, {30'd0, 1'b0, 1'b1});
        skip(1);
        chk("hw_rst_high_first", {30'd0, lcd_rst_n, busy}, {30'd0, 1'b1, 1'b1});
        skip(7);
        chk("hw_wait_last", {31'd0, wr_valid}, 32'd0);
        skip(2);
        chk("hw_first_issue", {22'd0, wr_valid, wr_dc, wr_data}, {22'd0, 1'b1, 1'b0, 8'h11});
        wait_done("hw_done", 50);
`endif

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
